// File: rtl/da_fir_serial.sv
// Bit-serial distributed-arithmetic FIR filter with run-time programmable coefficients.
// Processes one bit-slice of the delay line per cycle, LSB first, then saturates the result to OUT_W.
module da_fir_serial #(
  parameter int DATA_W    = 8,
  parameter int TAPS      = 7,
  parameter int COEF_W    = 10,
  parameter int OUT_W     = 10,
  parameter int OUT_SHIFT = 8,
  localparam int AW       = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [OUT_W-1:0]  y_out,
  output logic                     out_valid,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  output logic                     busy
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS) + 1;
  localparam int BW    = $clog2(DATA_W);

  localparam logic [BW-1:0]           LastBit  = BW'(DATA_W - 1);
  localparam logic [AW:0]             TapCount = (AW + 1)'(TAPS);
  localparam logic signed [ACC_W-1:0] YMax     = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] YMin     = ACC_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic {IDLE, CALC} state_t;

  state_t                    state_q, state_d;
  logic [DATA_W-1:0]         taps_q [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   psum, slice, shifted;
  logic [BW-1:0]             bitCnt_q;
  logic signed [OUT_W-1:0]   y_q, y_d;
  logic                      outValid_q, coefErr_q, coefErr_d;
  logic                      accept, lastSlice, coefWrite;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    lastSlice = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (bitCnt_q == LastBit) begin
          lastSlice = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == CALC);

  // Writes land only while idle and in range; an idle write still applies to a sample accepted on the same edge.
  always_comb begin
    coefWrite = coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < TapCount);
    coefErr_d = coef_we && !coefWrite;
  end

  always_comb begin
    psum = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (taps_q[k][bitCnt_q]) psum = psum + ACC_W'(coef_q[k]);
    end
  end

  // The MSB slice carries negative weight in two's complement, so it is subtracted.
  always_comb begin
    slice   = psum <<< bitCnt_q;
    acc_d   = lastSlice ? (acc_q - slice) : (acc_q + slice);
    shifted = acc_d >>> OUT_SHIFT;
    if (shifted > YMax)      y_d = YMax[OUT_W-1:0];
    else if (shifted < YMin) y_d = YMin[OUT_W-1:0];
    else                     y_d = shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        taps_q[k] <= '0;
        coef_q[k] <= '0;
      end
      acc_q      <= '0;
      bitCnt_q   <= '0;
      y_q        <= '0;
      outValid_q <= 1'b0;
      coefErr_q  <= 1'b0;
    end else begin
      outValid_q <= lastSlice;
      coefErr_q  <= coefErr_d;
      if (lastSlice) y_q <= y_d;
      if (coefWrite) coef_q[coef_addr] <= coef_data;
      if (accept) begin
        taps_q[0] <= x_in;
        for (int k = 1; k < TAPS; k++) taps_q[k] <= taps_q[k-1];
        acc_q    <= '0;
        bitCnt_q <= '0;
      end else if (state_q == CALC) begin
        acc_q    <= acc_d;
        bitCnt_q <= bitCnt_q + 1'b1;
      end
    end
  end

  assign y_out     = y_q;
  assign out_valid = outValid_q;
  assign coef_err  = coefErr_q;

endmodule

// File: tb/tb_da_fir_serial.sv
// Self-checking bench for da_fir_serial: two instances share stimulus, one with a wide output
// and one with a 10-bit output so the same samples exercise both the exact and the saturated paths.
module tb_da_fir_serial;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [7:0]  x_in = '0;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [9:0]  coef_data = '0;

  logic               inReadyA, outValidA, coefErrA, busyA;
  logic signed [15:0] yA;
  logic               inReadyB, outValidB, coefErrB, busyB;
  logic signed [9:0]  yB;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic signed [7:0] x;
    int                expA;
    int                expB;
  } vec_t;

  vec_t vecs [35];

  da_fir_serial #(.DATA_W(8), .TAPS(7), .COEF_W(10), .OUT_W(16), .OUT_SHIFT(0)) dutA (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyA), .x_in(x_in),
    .y_out(yA), .out_valid(outValidA), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coefErrA), .busy(busyA)
  );

  da_fir_serial #(.DATA_W(8), .TAPS(7), .COEF_W(10), .OUT_W(10), .OUT_SHIFT(0)) dutB (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyB), .x_in(x_in),
    .y_out(yB), .out_valid(outValidB), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coefErrB), .busy(busyB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic setVec(input int idx, input logic signed [7:0] x, input int expA, input int expB);
    vecs[idx].x    = x;
    vecs[idx].expA = expA;
    vecs[idx].expB = expB;
  endtask

  task automatic writeCoef(input logic [2:0] addr, input logic signed [9:0] data, input int expErr);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
    checkOutput($sformatf("coef_err_addr%0d", addr), int'(coefErrA), expErr);
  endtask

  // Entered in the cycle right after the accept edge; expLat counts remaining negedges to out_valid.
  task automatic waitResult(input string tag, input int expA, input int expB, input int expLat);
    int cyc;
    cyc = 0;
    while (!outValidA && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, expLat);
    checkOutput({tag, "_yA"}, yA, expA);
    checkOutput({tag, "_yB"}, yB, expB);
    checkOutput({tag, "_validB"}, int'(outValidB), 1);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, int'(outValidA), 0);
  endtask

  task automatic applyStimulus(input logic signed [7:0] x, input int expA, input int expB, input string tag);
    in_valid = 1'b1;
    x_in     = x;
    checkOutput({tag, "_ready"}, int'(inReadyA), 1);
    @(negedge clk);
    in_valid = 1'b0;
    waitResult(tag, expA, expB, 8);
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(vecs[i].x, vecs[i].expA, vecs[i].expB, $sformatf("vec%0d", i));
  endtask

  initial begin
    int cnt;
    int seen;

    // coef = {1..7}: impulse, negative impulse, then a mixed stream
    for (int i = 0; i < 8; i++) setVec(i, (i == 0) ? 8'sd1 : 8'sd0, (i < 7) ? i + 1 : 0, (i < 7) ? i + 1 : 0);
    setVec(8,  -8'sd128, -128, -128);
    setVec(9,  8'sd0,    -256, -256);
    setVec(10, 8'sd0,    -384, -384);
    setVec(11, 8'sd0,    -512, -512);
    setVec(12, 8'sd0,    -640, -512);
    setVec(13, 8'sd0,    -768, -512);
    setVec(14, 8'sd0,    -896, -512);
    setVec(15, 8'sd0,    0,    0);
    setVec(16, 8'sd5,    5,    5);
    setVec(17, -8'sd3,   7,    7);
    setVec(18, 8'sd100,  109,  109);
    setVec(19, -8'sd100, 111,  111);
    setVec(20, 8'sd127,  240,  240);
    // all coef = 511: every sum lands outside both output ranges
    for (int i = 21; i < 28; i++) setVec(i, 8'sd127, 32767, 511);
    for (int i = 28; i < 31; i++) setVec(i, -8'sd128, 32767, 511);
    for (int i = 31; i < 35; i++) setVec(i, -8'sd128, -32768, -512);

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", int'(inReadyA), 1);
    checkOutput("rst_busy", int'(busyA), 0);
    checkOutput("rst_out_valid", int'(outValidA), 0);
    checkOutput("rst_y", yA, 0);
    checkOutput("rst_coef_err", int'(coefErrA), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) writeCoef(3'(k), 10'(k + 1), 0);
    runVectors(0, 20);
    for (int k = 0; k < 7; k++) writeCoef(3'(k), 10'sd511, 0);
    runVectors(21, 34);

    // in_valid held high: each accept must be followed by 8 busy cycles and coincide with out_valid
    x_in     = 8'sd0;
    in_valid = 1'b1;
    checkOutput("hs_first_ready", int'(inReadyA), 1);
    for (int a = 0; a < 8; a++) begin
      cnt = 0;
      @(negedge clk);
      while (!inReadyA && cnt < 20) begin
        cnt++;
        @(negedge clk);
      end
      checkOutput($sformatf("hs_busy_cycles%0d", a), cnt, 8);
      checkOutput($sformatf("hs_accept_valid%0d", a), int'(outValidA), 1);
    end
    in_valid = 1'b0;
    @(negedge clk);

    writeCoef(3'd0, 10'sd3, 0);
    in_valid = 1'b1;
    x_in     = 8'sd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 10'sd100;
    @(negedge clk);
    coef_we = 1'b0;
    checkOutput("calc_write_err", int'(coefErrA), 1);
    checkOutput("calc_busy", int'(busyA), 1);
    checkOutput("calc_not_ready", int'(inReadyA), 0);
    @(negedge clk);
    checkOutput("calc_err_pulse", int'(coefErrA), 0);
    waitResult("calc_write", 3, 3, 5);

    writeCoef(3'd7, 10'sd55, 1);
    applyStimulus(8'sd2, 517, 511, "coef_kept");

    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 10'sd5;
    in_valid  = 1'b1;
    x_in      = 8'sd1;
    @(negedge clk);
    coef_we  = 1'b0;
    in_valid = 1'b0;
    checkOutput("same_edge_err", int'(coefErrA), 0);
    waitResult("same_edge", 1538, 511, 8);

    // reset asserted while the fifth slice is in flight
    in_valid = 1'b1;
    x_in     = 8'sd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_in_ready", int'(inReadyA), 1);
    checkOutput("abort_busy", int'(busyA), 0);
    checkOutput("abort_yA", yA, 0);
    checkOutput("abort_yB", yB, 0);
    checkOutput("abort_out_valid", int'(outValidA), 0);
    checkOutput("abort_coef_err", int'(coefErrA), 0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (outValidA) seen++;
    end
    checkOutput("abort_no_valid", seen, 0);
    applyStimulus(8'sd1, 0, 0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/da_fir_serial.md
Name: da_fir_serial

Overview:
- Bit-serial, parametrised distributed-arithmetic FIR filter with run-time programmable coefficients.
- The partial-sum table is formed from the coefficient registers: the table output is the sum of the coefficients selected by one bit-slice of the delay line.
- Each accepted sample is processed one bit per cycle, LSB first, and the result is saturated to the output width.
- Sits in the filter datapath where area matters more than throughput. Valid/ready input, valid-pulse output.

Parameters:
- DATA_W, 8, input sample width (signed two's complement), >=2
- TAPS, 7, number of taps (delay-line length), 2..16
- COEF_W, 10, coefficient width (signed)
- OUT_W, 10, output width (signed)
- OUT_SHIFT, 8, arithmetic right shift applied to the full sum before saturation
- Localparams:
  - ACC_W = DATA_W+COEF_W+$clog2(TAPS)+1
  - AW = $clog2(TAPS)
  - BW = $clog2(DATA_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- x_in  in  DATA_W  signed input sample
- y_out  out  OUT_W  signed filtered output, held between results
- out_valid  out  1  one-cycle pulse: y_out updated
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  tap index, 0 = newest sample
- coef_data  in  COEF_W  signed coefficient value
- coef_err  out  1  one-cycle pulse: write dropped
- busy  out  1  computation in progress

Behaviour:
- **Reset (rst=0, async):**
  - state=IDLE.
  - Delay line, coefficients, accumulator, bit counter all 0.
  - y_out=0, out_valid=0, coef_err=0, in_ready=1, busy=0.
  - Reset mid-computation aborts; no out_valid is produced.
- **States:** IDLE, CALC.
  - IDLE: in_ready=1, busy=0.
  - IDLE -> CALC on in_valid&&in_ready. At that edge, x_in shifts into tap 0, taps shift 0->1->...->TAPS-1, the oldest sample is discarded, acc=0 and bit=0.
  - CALC: in_ready=0, busy=1. One bit-slice per cycle, bit = 0..DATA_W-1.
  - P(b) = sum over k of coef[k] where tap[k][b]=1. Sign-extend P(b) to ACC_W.
  - acc += P(b)<<b for b<DATA_W-1; acc -= P(b)<<(DATA_W-1) at the MSB slice (two's-complement weight).
  - CALC -> IDLE after the bit=DATA_W-1 cycle. At that same edge, y_out is registered and out_valid=1 for exactly one cycle.
- **Output arithmetic:**
  - t = (final acc) >>> OUT_SHIFT, floor.
  - y_out = t clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - No rounding.
- **Latency and throughput:**
  - Sample accepted at edge N gives out_valid high in the cycle after edge N+DATA_W.
  - Throughput is one sample per DATA_W+1 cycles.
- **Back-to-back:** in the out_valid cycle the block is in IDLE with in_ready=1. A new sample may be accepted in that same cycle.
- **in_valid during CALC:** ignored; the upstream holds it.
- **Coefficient writes:**
  - Accepted in IDLE only: coef[coef_addr] <= coef_data at the edge.
  - A write in CALC is dropped and coef_err pulses one cycle.
  - coef_addr >= TAPS is dropped and coef_err pulses.
  - A write in the same cycle as sample acceptance takes effect, so the new sample uses the new coefficient.
- **Sum width:** the full sum never overflows ACC_W. Saturation occurs only at the output.

Test Plan:
- **Impulse:** coef={1,2,3,4,5,6,7}, OUT_SHIFT=0, OUT_W=16; feed 1 then 7 zeros -> y_out sequence 1,2,3,4,5,6,7,0, each out_valid exactly 9 cycles after acceptance.
- **Negative MSB:** same coefs, feed -128 then zeros -> y_out -128,-256,...,-896, then 0.
- **Saturation:** all coef=511, OUT_SHIFT=0, OUT_W=10; feed 127 x7 -> y_out=511. Feed -128 x7 -> y_out=-512.
- **Handshake:** in_valid held high continuously -> in_ready low for 8 cycles after each accept. Accepts every 9 cycles, with the accept coinciding with out_valid.
- **Coefficient errors:** coef_we during CALC -> coef_err=1 for one cycle, coefficient unchanged. coef_addr=7 in IDLE -> coef_err=1.
- **Reset abort:** assert rst low at bit=4 -> all outputs 0 immediately, no out_valid. After release, in_ready=1 and the next impulse reproduces the reset-state response (all-zero coefficients -> y_out=0).
